register_file: RTL

//   32 x 32-bit MiniMIPS general-purpose register file; the stage directly upstream of the ALU.

---
 rtl/register_file.sv | 87 ++++++++
 1 files changed

// File: rtl/register_file.sv
// MiniMIPS 32-entry general-purpose register file feeding the ALU.
// Registered dual read with write-first bypass; r0 reads zero, $sp resets to top of data memory.
module register_file #(
   parameter int                DATA_WIDTH = 32,
   parameter int                ADDR_WIDTH = 5,
   parameter int                SP_INDEX   = 29,
   parameter logic [DATA_WIDTH-1:0] SP_RESET = 32'h03ffffff
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  READ,
   input  logic                  WRITE,
   input  logic [ADDR_WIDTH-1:0] ADDR_R1,
   input  logic [ADDR_WIDTH-1:0] ADDR_R2,
   input  logic [ADDR_WIDTH-1:0] ADDR_W,
   input  logic [DATA_WIDTH-1:0] DATA_W,
   output logic [DATA_WIDTH-1:0] DATA_R1,
   output logic [DATA_WIDTH-1:0] DATA_R2,
   output logic                  RD_VALID
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs_q [DEPTH];
   logic [DATA_WIDTH-1:0] dataR1_q, dataR1_d;
   logic [DATA_WIDTH-1:0] dataR2_q, dataR2_d;
   logic                  rdValid_q, rdValid_d;
   logic                  writeEn;
   logic                  bypassR1;
   logic                  bypassR2;

   // Writes to r0 are dropped so the array entry stays zero forever.
   assign writeEn  = WRITE && (ADDR_W != '0);
   assign bypassR1 = writeEn && (ADDR_W == ADDR_R1);
   assign bypassR2 = writeEn && (ADDR_W == ADDR_R2);

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs_q[i] <= (i == SP_INDEX) ? SP_RESET : '0;
         end
      end else if (writeEn) begin
         regs_q[ADDR_W] <= DATA_W;
      end
   end

   // Read path: hold outputs when idle; a same-edge write wins over the stored value.
   always_comb begin
      dataR1_d  = dataR1_q;
      dataR2_d  = dataR2_q;
      rdValid_d = 1'b0;
      if (READ) begin
         rdValid_d = 1'b1;
         if (ADDR_R1 == '0) begin
            dataR1_d = '0;
         end else if (bypassR1) begin
            dataR1_d = DATA_W;
         end else begin
            dataR1_d = regs_q[ADDR_R1];
         end
         if (ADDR_R2 == '0) begin
            dataR2_d = '0;
         end else if (bypassR2) begin
            dataR2_d = DATA_W;
         end else begin
            dataR2_d = regs_q[ADDR_R2];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         dataR1_q  <= '0;
         dataR2_q  <= '0;
         rdValid_q <= 1'b0;
      end else begin
         dataR1_q  <= dataR1_d;
         dataR2_q  <= dataR2_d;
         rdValid_q <= rdValid_d;
      end
   end

   assign DATA_R1  = dataR1_q;
   assign DATA_R2  = dataR2_q;
   assign RD_VALID = rdValid_q;

endmodule
